// File: rtl/bsv_method_caller.sv
// bsv_method_caller: caller end of a BSV ActionValue method port.
// Requests {a,b,c} are queued, packed MSB-first onto m_in1 and issued with
// EN_m when the callee is ready and there is room for the result; results are
// queued and returned as unpacked fields in request order.
// Optional build macro: BSV_METHOD_CALLER_STATS_EN adds call_count/stall_count.
module bsv_method_caller #(
  parameter int FIELD_W   = 4,
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [FIELD_W-1:0]   req_a,
  input  logic [FIELD_W-1:0]   req_b,
  input  logic [FIELD_W-1:0]   req_c,
  input  logic                 RDY_m,
  output logic                 EN_m,
  output logic [3*FIELD_W-1:0] m_in1,
  input  logic [3*FIELD_W-1:0] m_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [FIELD_W-1:0]   rsp_a,
  output logic [FIELD_W-1:0]   rsp_b,
  output logic [FIELD_W-1:0]   rsp_c,
`ifdef BSV_METHOD_CALLER_STATS_EN
  output logic [15:0]          call_count,
  output logic [15:0]          stall_count,
`endif
  output logic                 busy
);

  localparam int DW = 3 * FIELD_W;
  localparam int QA = $clog2(REQ_DEPTH);
  localparam int SA = $clog2(RSP_DEPTH);
  localparam logic [QA:0] REQ_FULL = (QA+1)'(REQ_DEPTH);
  localparam logic [SA:0] RSP_FULL = (SA+1)'(RSP_DEPTH);

  logic [DW-1:0] req_mem [REQ_DEPTH];
  logic [QA-1:0] req_wr, req_rd;
  logic [QA:0]   req_cnt;
  logic [DW-1:0] rsp_mem [RSP_DEPTH];
  logic [SA-1:0] rsp_wr, rsp_rd;
  logic [SA:0]   rsp_cnt;
  logic          rst_done;

  logic req_nonempty, rsp_nonempty, rsp_notfull;
  logic req_push, rsp_pop;
  logic [DW-1:0] rsp_head;

  assign req_nonempty = (req_cnt != '0);
  assign rsp_nonempty = (rsp_cnt != '0);
  assign rsp_notfull  = (rsp_cnt != RSP_FULL);

  // req_ready stays low through reset and its first released edge
  assign req_ready = rst_done & (req_cnt != REQ_FULL);
  assign req_push  = req_valid & req_ready;
  // rsp_ready deliberately absent: a same-cycle pop never frees a slot for the call
  assign EN_m      = RDY_m & req_nonempty & rsp_notfull;
  assign rsp_valid = rsp_nonempty;
  assign rsp_pop   = rsp_valid & rsp_ready;
  assign busy      = req_nonempty | rsp_nonempty;

  assign m_in1    = req_nonempty ? req_mem[req_rd] : '0;
  assign rsp_head = rsp_nonempty ? rsp_mem[rsp_rd] : '0;
  assign rsp_a    = rsp_head[3*FIELD_W-1:2*FIELD_W];
  assign rsp_b    = rsp_head[2*FIELD_W-1:FIELD_W];
  assign rsp_c    = rsp_head[FIELD_W-1:0];

  // Marks the first clock edge after reset release
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rst_done <= 1'b0;
    else        rst_done <= 1'b1;
  end

  // Storage arrays carry no reset; outputs are masked while empty
  always_ff @(posedge CLK) begin
    if (req_push) req_mem[req_wr] <= {req_a, req_b, req_c};
    if (EN_m)     rsp_mem[rsp_wr] <= m_result;
  end

  // Request FIFO pointers and occupancy
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      req_wr  <= '0;
      req_rd  <= '0;
      req_cnt <= '0;
    end else begin
      if (req_push) req_wr <= req_wr + QA'(1);
      if (EN_m)     req_rd <= req_rd + QA'(1);
      case ({req_push, EN_m})
        2'b10:   req_cnt <= req_cnt + (QA+1)'(1);
        2'b01:   req_cnt <= req_cnt - (QA+1)'(1);
        default: req_cnt <= req_cnt;
      endcase
    end
  end

  // Response FIFO pointers and occupancy
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rsp_wr  <= '0;
      rsp_rd  <= '0;
      rsp_cnt <= '0;
    end else begin
      if (EN_m)    rsp_wr <= rsp_wr + SA'(1);
      if (rsp_pop) rsp_rd <= rsp_rd + SA'(1);
      case ({EN_m, rsp_pop})
        2'b10:   rsp_cnt <= rsp_cnt + (SA+1)'(1);
        2'b01:   rsp_cnt <= rsp_cnt - (SA+1)'(1);
        default: rsp_cnt <= rsp_cnt;
      endcase
    end
  end

`ifdef BSV_METHOD_CALLER_STATS_EN
  // Call counter wraps; stall counter (work ready but callee not) saturates
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      call_count  <= '0;
      stall_count <= '0;
    end else begin
      if (EN_m) call_count <= call_count + 16'd1;
      if (req_nonempty && rsp_notfull && !RDY_m && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bsv_method_caller.sv
// Directed self-checking bench for bsv_method_caller (FIELD_W=4, depths 4).
module tb_bsv_method_caller;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        req_valid, req_ready;
  logic [3:0]  req_a, req_b, req_c;
  logic        RDY_m, EN_m;
  logic [11:0] m_in1, m_result;
  logic        rsp_valid, rsp_ready;
  logic [3:0]  rsp_a, rsp_b, rsp_c;
  logic        busy;
`ifdef BSV_METHOD_CALLER_STATS_EN
  logic [15:0] call_count, stall_count;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  bsv_method_caller #(.FIELD_W(4), .REQ_DEPTH(4), .RSP_DEPTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .RDY_m(RDY_m), .EN_m(EN_m), .m_in1(m_in1), .m_result(m_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_c(rsp_c),
`ifdef BSV_METHOD_CALLER_STATS_EN
    .call_count(call_count), .stall_count(stall_count),
`endif
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  function automatic logic [11:0] val(input int i);
    return 12'(i * 53 + 7);
  endfunction

  initial begin
    RST_N = 1'b0; req_valid = 1'b0; {req_a, req_b, req_c} = 12'h0;
    RDY_m = 1'b1; m_result = 12'h0; rsp_ready = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_en", EN_m, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_in1", m_in1, 0);
    chk("rst_rsp", {rsp_a, rsp_b, rsp_c}, 0);
    step(); step();
    RST_N = 1'b1;
    step();
    #1 chk("post_rst_req_ready", req_ready, 1);

    // single call: push 123, result ABC
    req_valid = 1'b1; {req_a, req_b, req_c} = 12'h123; m_result = 12'hABC;
    #1 chk("t1_en_before_push", EN_m, 0);
    step();
    req_valid = 1'b0;
    #1;
    chk("t1_en", EN_m, 1);
    chk("t1_m_in1", m_in1, 12'h123);
    step();
    #1;
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp", {rsp_a, rsp_b, rsp_c}, 12'hABC);
    chk("t1_en_after", EN_m, 0);
    chk("t1_busy", busy, 1);
    rsp_ready = 1'b1;
    step();
    #1;
    chk("t1_rsp_drained", rsp_valid, 0);
    chk("t1_idle", busy, 0);
    rsp_ready = 1'b0;

    // RDY_m low: fill request FIFO, then release
    RDY_m = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      req_valid = 1'b1; {req_a, req_b, req_c} = 12'(i * 12'h111);
      #1 chk("t2_en_held", EN_m, 0);
      step();
    end
    req_valid = 1'b1; {req_a, req_b, req_c} = 12'h555;
    #1;
    chk("t2_full_ready", req_ready, 0);
    chk("t2_full_en", EN_m, 0);
    step();
    req_valid = 1'b0; RDY_m = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      m_result = 12'(12'h100 + i);
      #1;
      chk("t2_call_en", EN_m, 1);
      chk("t2_call_arg", m_in1, 12'(i * 12'h111));
      step();
    end
    #1;
    chk("t2_no_extra_call", EN_m, 0);
    chk("t2_rsp_full_busy", busy, 1);
    rsp_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("t2_rsp_valid", rsp_valid, 1);
      chk("t2_rsp", {rsp_a, rsp_b, rsp_c}, 12'(12'h100 + i));
      step();
    end
    #1 chk("t2_rsp_empty", rsp_valid, 0);

    // response backpressure: 6 pushes, only 4 calls fit
    rsp_ready = 1'b0; RDY_m = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      req_valid = 1'b1; {req_a, req_b, req_c} = {4'h6, 4'h0, 4'(k)};
      m_result = 12'(12'hC00 + k);
      #1;
      chk("t3_push_ready", req_ready, 1);
      chk("t3_en", EN_m, (k >= 2 && k <= 5) ? 1 : 0);
      if (k >= 2 && k <= 5) chk("t3_arg", m_in1, {4'h6, 4'h0, 4'(k - 1)});
      step();
    end
    req_valid = 1'b0; m_result = 12'hBAD;
    #1;
    chk("t3_stalled_en", EN_m, 0);
    chk("t3_pending_head", m_in1, 12'h605);
    chk("t3_rsp_head", {rsp_a, rsp_b, rsp_c}, 12'hC02);
    step();
    #1 chk("t3_rsp_hold", {rsp_a, rsp_b, rsp_c}, 12'hC02);
    rsp_ready = 1'b1;
    #1 chk("t3_full_pop_no_call", EN_m, 0);
    step();
    m_result = 12'hC55;
    #1;
    chk("t3_call5_en", EN_m, 1);
    chk("t3_call5_arg", m_in1, 12'h605);
    chk("t3_rsp3", {rsp_a, rsp_b, rsp_c}, 12'hC03);
    step();
    m_result = 12'hC66;
    #1;
    chk("t3_call6_en", EN_m, 1);
    chk("t3_call6_arg", m_in1, 12'h606);
    chk("t3_rsp4", {rsp_a, rsp_b, rsp_c}, 12'hC04);
    step();
    #1 chk("t3_done_en", EN_m, 0);
    chk("t3_rsp5", {rsp_a, rsp_b, rsp_c}, 12'hC05);
    step();
    #1 chk("t3_rsp55", {rsp_a, rsp_b, rsp_c}, 12'hC55);
    step();
    #1 chk("t3_rsp66", {rsp_a, rsp_b, rsp_c}, 12'hC66);
    step();
    #1;
    chk("t3_drained", rsp_valid, 0);
    chk("t3_idle", busy, 0);

    // 20-request stream, one call per cycle
    for (int i = 0; i <= 21; i++) begin
      if (i < 20) begin
        req_valid = 1'b1; {req_a, req_b, req_c} = val(i);
      end else begin
        req_valid = 1'b0;
      end
      m_result = 12'(12'h800 + i);
      #1;
      chk("t4_en", EN_m, (i >= 1 && i <= 20) ? 1 : 0);
      if (i >= 1 && i <= 20) chk("t4_arg", m_in1, val(i - 1));
      chk("t4_rsp_valid", rsp_valid, (i >= 2) ? 1 : 0);
      if (i >= 2) chk("t4_rsp", {rsp_a, rsp_b, rsp_c}, 12'(12'h800 + i - 1));
      if (i < 20) chk("t4_ready", req_ready, 1);
      step();
    end
    #1 chk("t4_end_empty", rsp_valid, 0);

    // reset with 3 requests queued and 2 responses pending
    rsp_ready = 1'b0; RDY_m = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      req_valid = 1'b1; {req_a, req_b, req_c} = 12'(12'hA00 + i);
      step();
    end
    req_valid = 1'b0; RDY_m = 1'b1; m_result = 12'hE0E;
    step(); step();
    RDY_m = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      req_valid = 1'b1; {req_a, req_b, req_c} = 12'(12'hA00 + i);
      step();
    end
    req_valid = 1'b0;
    #1;
    chk("t5_pre_busy", busy, 1);
    chk("t5_pre_rsp_valid", rsp_valid, 1);
    chk("t5_pre_head", m_in1, 12'hA03);
    RDY_m = 1'b1; RST_N = 1'b0;
    #1;
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_en", EN_m, 0);
    chk("t5_rst_rsp_valid", rsp_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_m_in1", m_in1, 0);
    chk("t5_rst_rsp", {rsp_a, rsp_b, rsp_c}, 0);
    step();
    #1 chk("t5_rst_en_held", EN_m, 0);
    RST_N = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_post_ready", req_ready, 1);
      chk("t5_post_rsp_valid", rsp_valid, 0);
      chk("t5_post_en", EN_m, 0);
      chk("t5_post_busy", busy, 0);
      step();
    end

`ifdef BSV_METHOD_CALLER_STATS_EN
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    step();
    #1;
    chk("t6_rst_calls", call_count, 0);
    chk("t6_rst_stalls", stall_count, 0);
    rsp_ready = 1'b1; RDY_m = 1'b0;
    req_valid = 1'b1; {req_a, req_b, req_c} = 12'h001;
    step();
    req_valid = 1'b0;
    step(); step(); step();
    #1;
    chk("t6_stalls_mid", stall_count, 3);
    chk("t6_calls_mid", call_count, 0);
    RDY_m = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      req_valid = 1'b1; {req_a, req_b, req_c} = 12'(i);
      step();
    end
    req_valid = 1'b0;
    step(); step(); step();
    #1;
    chk("t6_calls", call_count, 5);
    chk("t6_stalls", stall_count, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
